// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer driven by a once-per-second tick.
// Start/pause/clear control, preset load with digit validation, registered expiry pulse.
module countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic        clk_100MHz_i,
    input  logic        reset_n_i,
    input  logic        second_pulse_i,
    input  logic        load_i,
    input  logic [15:0] load_value_i,
    input  logic        start_i,
    input  logic        pause_i,
    input  logic        clear_i,
    output logic [15:0] time_o,
    output logic        running_o,
    output logic        done_o,
    output logic        expired_o,
    output logic        load_error_o
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned TIME_W  = 4 * DIGIT_W;

    typedef struct packed {
        logic [DIGIT_W-1:0] m_tens;
        logic [DIGIT_W-1:0] m_units;
        logic [DIGIT_W-1:0] s_tens;
        logic [DIGIT_W-1:0] s_units;
    } bcd_time_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam bcd_time_t TIME_ZERO = bcd_time_t'(TIME_W'(0));

    state_t    state_q, state_d;
    bcd_time_t time_q, time_d;
    bcd_time_t preset_q, preset_d;
    logic      running_q, running_d;
    logic      done_q, done_d;
    logic      expired_q, expired_d;
    logic      load_error_q, load_error_d;

    // Digit-wise decrement with borrow ripple; never touches the packed word as a number.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s_units != DIGIT_W'(0)) begin
            r.s_units = t.s_units - DIGIT_W'(1);
        end else begin
            r.s_units = DIGIT_W'(9);
            if (t.s_tens != DIGIT_W'(0)) begin
                r.s_tens = t.s_tens - DIGIT_W'(1);
            end else begin
                r.s_tens = DIGIT_W'(5);
                if (t.m_units != DIGIT_W'(0)) begin
                    r.m_units = t.m_units - DIGIT_W'(1);
                end else begin
                    r.m_units = DIGIT_W'(9);
                    r.m_tens  = t.m_tens - DIGIT_W'(1);
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input bcd_time_t t);
        return (t.m_tens  <= DIGIT_W'(9)) && (t.m_units <= DIGIT_W'(9)) &&
               (t.s_tens  <= DIGIT_W'(5)) && (t.s_units <= DIGIT_W'(9));
    endfunction

    bcd_time_t load_value;
    bcd_time_t time_dec;
    logic      do_load;
    logic      do_pause;
    logic      do_start;
    logic      do_tick;

    // Effective commands: each already qualified by the state in which it acts.
    always_comb begin
        load_value = bcd_time_t'(load_value_i);
        time_dec   = bcd_dec(time_q);
        do_load    = load_i && (state_q != RUN);
        do_pause   = pause_i && (state_q == RUN);
        do_start   = start_i && ((state_q == IDLE) || (state_q == PAUSED)) &&
                     (time_q != TIME_ZERO);
        do_tick    = second_pulse_i && (state_q == RUN);
    end

    always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            time_q       <= TIME_ZERO;
            preset_q     <= TIME_ZERO;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            expired_q    <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            preset_q     <= preset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            expired_q    <= expired_d;
            load_error_q <= load_error_d;
        end
    end

    // Priority: clear > load > pause > start > tick.
    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        preset_d     = preset_q;
        expired_d    = 1'b0;
        load_error_d = 1'b0;

        if (clear_i) begin
            state_d = IDLE;
            time_d  = TIME_ZERO;
        end else if (do_load) begin
            if (bcd_valid(load_value)) begin
                time_d   = load_value;
                preset_d = load_value;
                state_d  = IDLE;
            end else begin
                load_error_d = 1'b1;
            end
        end else if (do_pause) begin
            state_d = PAUSED;
        end else if (do_start) begin
            state_d = RUN;
        end else if (do_tick) begin
            if (time_dec == TIME_ZERO) begin
                expired_d = 1'b1;
                if (AUTO_RELOAD && (preset_q != TIME_ZERO)) begin
                    time_d = preset_q;
                end else begin
                    time_d  = TIME_ZERO;
                    state_d = DONE;
                end
            end else begin
                time_d = time_dec;
            end
        end

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    assign time_o       = time_q;
    assign running_o    = running_q;
    assign done_o       = done_q;
    assign expired_o    = expired_q;
    assign load_error_o = load_error_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance without and one with auto-reload,
// sharing the same stimulus.
module tb_countdown_timer;

    logic        clk_100MHz_i = 1'b0;
    logic        reset_n_i;
    logic        second_pulse_i;
    logic        load_i;
    logic [15:0] load_value_i;
    logic        start_i;
    logic        pause_i;
    logic        clear_i;

    logic [15:0] time0, time1;
    logic        running0, running1;
    logic        done0, done1;
    logic        expired0, expired1;
    logic        lerr0, lerr1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_100MHz_i = ~clk_100MHz_i;

    countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk_100MHz_i   (clk_100MHz_i),
        .reset_n_i      (reset_n_i),
        .second_pulse_i (second_pulse_i),
        .load_i         (load_i),
        .load_value_i   (load_value_i),
        .start_i        (start_i),
        .pause_i        (pause_i),
        .clear_i        (clear_i),
        .time_o         (time0),
        .running_o      (running0),
        .done_o         (done0),
        .expired_o      (expired0),
        .load_error_o   (lerr0)
    );

    countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk_100MHz_i   (clk_100MHz_i),
        .reset_n_i      (reset_n_i),
        .second_pulse_i (second_pulse_i),
        .load_i         (load_i),
        .load_value_i   (load_value_i),
        .start_i        (start_i),
        .pause_i        (pause_i),
        .clear_i        (clear_i),
        .time_o         (time1),
        .running_o      (running1),
        .done_o         (done1),
        .expired_o      (expired1),
        .load_error_o   (lerr1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set before the call are sampled on it.
    task automatic step();
        @(posedge clk_100MHz_i);
        #1;
    endtask

    task automatic idle_inputs();
        second_pulse_i = 1'b0;
        load_i         = 1'b0;
        start_i        = 1'b0;
        pause_i        = 1'b0;
        clear_i        = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_i = 1'b1; load_value_i = v; step(); idle_inputs();
    endtask

    task automatic do_start();
        start_i = 1'b1; step(); idle_inputs();
    endtask

    task automatic do_clear();
        clear_i = 1'b1; step(); idle_inputs();
    endtask

    // Tick after nine quiet cycles, so ticks land ten cycles apart.
    task automatic do_tick();
        repeat (9) step();
        second_pulse_i = 1'b1; step(); idle_inputs();
    endtask

    initial begin
        reset_n_i    = 1'b0;
        load_value_i = 16'h0000;
        idle_inputs();
        step(); step();
        chk("rst_time",    time0, 16'h0000);
        chk("rst_running", 16'(running0), 16'h0);
        chk("rst_done",    16'(done0), 16'h0);
        chk("rst_expired", 16'(expired0), 16'h0);
        chk("rst_lerr",    16'(lerr0), 16'h0);
        reset_n_i = 1'b1;
        step();

        // Basic countdown to expiry
        do_load(16'h0003);
        chk("t1_load", time0, 16'h0003);
        do_start();
        chk("t1_running", 16'(running0), 16'h1);
        do_tick();
        chk("t1_tick1", time0, 16'h0002);
        chk("t1_noexp1", 16'(expired0), 16'h0);
        do_tick();
        chk("t1_tick2", time0, 16'h0001);
        do_tick();
        chk("t1_tick3", time0, 16'h0000);
        chk("t1_expired", 16'(expired0), 16'h1);
        chk("t1_done", 16'(done0), 16'h1);
        chk("t1_running_off", 16'(running0), 16'h0);
        step();
        chk("t1_exp_width", 16'(expired0), 16'h0);

        // Full borrow chain
        do_load(16'h1000);
        chk("t2_load", time0, 16'h1000);
        chk("t2_done_off", 16'(done0), 16'h0);
        do_start();
        do_tick();
        chk("t2_borrow", time0, 16'h0959);
        do_tick();
        chk("t2_tick2", time0, 16'h0958);

        // Load validation (from PAUSED)
        pause_i = 1'b1; step(); idle_inputs();
        chk("t3_paused", 16'(running0), 16'h0);
        do_load(16'h0060);
        chk("t3_err_stens", 16'(lerr0), 16'h1);
        chk("t3_keep1", time0, 16'h0958);
        step();
        chk("t3_err_width", 16'(lerr0), 16'h0);
        do_load(16'h0A00);
        chk("t3_err_munits", 16'(lerr0), 16'h1);
        chk("t3_keep2", time0, 16'h0958);
        do_load(16'h9959);
        chk("t3_accept", time0, 16'h9959);
        chk("t3_no_err", 16'(lerr0), 16'h0);

        // Pause/tick and start/tick collisions
        do_load(16'h0005);
        do_start();
        pause_i = 1'b1; second_pulse_i = 1'b1; step(); idle_inputs();
        chk("t4_pause_time", time0, 16'h0005);
        chk("t4_pause_run", 16'(running0), 16'h0);
        chk("t4_pause_done", 16'(done0), 16'h0);
        start_i = 1'b1; second_pulse_i = 1'b1; step(); idle_inputs();
        chk("t4_start_time", time0, 16'h0005);
        chk("t4_start_run", 16'(running0), 16'h1);
        do_tick();
        chk("t4_next_tick", time0, 16'h0004);

        // Auto-reload (dut1) alongside stop-on-expiry (dut0)
        do_clear();
        chk("t5_clr0", time0, 16'h0000);
        chk("t5_clr1", time1, 16'h0000);
        do_load(16'h0002);
        do_start();
        do_tick();
        chk("t5_ar_tick1", time1, 16'h0001);
        do_tick();
        chk("t5_ar_reload", time1, 16'h0002);
        chk("t5_ar_expired", 16'(expired1), 16'h1);
        chk("t5_ar_running", 16'(running1), 16'h1);
        chk("t5_nr_time", time0, 16'h0000);
        chk("t5_nr_done", 16'(done0), 16'h1);
        do_clear();
        chk("t5_ar_clr_time", time1, 16'h0000);
        chk("t5_ar_clr_run", 16'(running1), 16'h0);
        chk("t5_ar_clr_exp", 16'(expired1), 16'h0);
        do_start();
        chk("t5_start_zero", 16'(running1), 16'h0);
        chk("t5_start_zero_t", time1, 16'h0000);

        // Load ignored in RUN, then asynchronous mid-run reset
        do_load(16'h0010);
        do_start();
        do_tick(); do_tick(); do_tick();
        chk("t6_count", time0, 16'h0007);
        do_load(16'h0030);
        chk("t6_load_in_run", time0, 16'h0007);
        chk("t6_still_run", 16'(running0), 16'h1);
        chk("t6_no_err", 16'(lerr0), 16'h0);
        @(negedge clk_100MHz_i);
        reset_n_i = 1'b0;
        #1;
        chk("t6_async_time", time0, 16'h0000);
        chk("t6_async_run", 16'(running0), 16'h0);
        chk("t6_async_done", 16'(done0), 16'h0);
        chk("t6_async_time1", time1, 16'h0000);
        step();
        reset_n_i = 1'b1;
        step();
        chk("t6_post_rst", time0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
